// File: rtl/jtkunio_gfx_rom_arb.sv
// Graphics ROM responder: char/scroll/object ports with one-entry tagged caches,
// arbitrated onto a single SDRAM read channel (fixed priority char > scr > obj).
module jtkunio_gfx_rom_arb #(
    parameter logic [21:0] CHAR_OFFSET = 22'h00000,
    parameter logic [21:0] SCR_OFFSET  = 22'h04000,
    parameter logic [21:0] OBJ_OFFSET  = 22'h24000
) (
    input  logic        clk,
    input  logic        rst_n,

    input  logic [13:0] char_addr,
    output logic [31:0] char_data,
    output logic        char_ok,

    input  logic [16:0] scr_addr,
    output logic [31:0] scr_data,
    output logic        scr_ok,

    input  logic        obj_cs,
    input  logic [17:0] obj_addr,
    output logic [31:0] obj_data,
    output logic        obj_ok,

    output logic [21:0] sdram_addr,
    output logic        sdram_req,
    input  logic        sdram_ack,
    input  logic        sdram_dst,
    input  logic [31:0] sdram_din
);

    localparam int NSLOT = 3;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_ACK  = 2'd1;
    localparam logic [1:0] ST_DATA = 2'd2;

    // Slot storage: tags are kept at the widest client width (18 bits).
    logic [17:0]      tag_q  [NSLOT];
    logic [31:0]      data_q [NSLOT];
    logic [NSLOT-1:0] valid_q;

    logic [17:0]      addr_ext [NSLOT];
    logic [21:0]      offset   [NSLOT];
    logic [NSLOT-1:0] cs;
    logic [NSLOT-1:0] ok;
    logic [NSLOT-1:0] miss;

    logic [1:0]  state_q, state_d;
    logic [1:0]  sel_q, sel_d;
    logic [17:0] req_tag_q, req_tag_d;
    logic [21:0] sdram_addr_q, sdram_addr_d;
    logic        sdram_req_q, sdram_req_d;
    logic        fill_en;

    assign addr_ext[0] = {4'd0, char_addr};
    assign addr_ext[1] = {1'b0, scr_addr};
    assign addr_ext[2] = obj_addr;

    assign offset[0] = CHAR_OFFSET;
    assign offset[1] = SCR_OFFSET;
    assign offset[2] = OBJ_OFFSET;

    assign cs = {obj_cs, 2'b11};

    // Hit compare is against the live address so ok drops in the same cycle it changes.
    genvar gi;
    generate
        for (gi = 0; gi < NSLOT; gi++) begin : g_slot
            assign ok[gi]   = cs[gi] && valid_q[gi] && (tag_q[gi] == addr_ext[gi]);
            assign miss[gi] = cs[gi] && !ok[gi];
        end
    endgenerate

    assign char_data = data_q[0];
    assign scr_data  = data_q[1];
    assign obj_data  = data_q[2];
    assign char_ok   = ok[0];
    assign scr_ok    = ok[1];
    assign obj_ok    = ok[2];

    assign sdram_addr = sdram_addr_q;
    assign sdram_req  = sdram_req_q;

    always_comb begin
        state_d      = state_q;
        sel_d        = sel_q;
        req_tag_d    = req_tag_q;
        sdram_addr_d = sdram_addr_q;
        sdram_req_d  = sdram_req_q;
        fill_en      = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (|miss) begin
                    if (miss[0])      sel_d = 2'd0;
                    else if (miss[1]) sel_d = 2'd1;
                    else              sel_d = 2'd2;
                    req_tag_d    = addr_ext[sel_d];
                    sdram_addr_d = offset[sel_d] + {4'd0, addr_ext[sel_d]};
                    sdram_req_d  = 1'b1;
                    state_d      = ST_ACK;
                end
            end
            ST_ACK: begin
                if (sdram_ack) begin
                    sdram_req_d = 1'b0;
                    // Data may come back together with the ack.
                    if (sdram_dst) begin
                        fill_en = 1'b1;
                        state_d = ST_IDLE;
                    end else begin
                        state_d = ST_DATA;
                    end
                end
            end
            ST_DATA: begin
                if (sdram_dst) begin
                    fill_en = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            sel_q        <= 2'd0;
            req_tag_q    <= '0;
            sdram_addr_q <= '0;
            sdram_req_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            sel_q        <= sel_d;
            req_tag_q    <= req_tag_d;
            sdram_addr_q <= sdram_addr_d;
            sdram_req_q  <= sdram_req_d;
        end
    end

    // The slot takes the latched request address as its tag, not the live input.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NSLOT; i++) begin
                tag_q[i]  <= '0;
                data_q[i] <= '0;
            end
            valid_q <= '0;
        end else if (fill_en) begin
            tag_q[sel_q]   <= req_tag_q;
            data_q[sel_q]  <= sdram_din;
            valid_q[sel_q] <= 1'b1;
        end
    end

endmodule

// File: tb/tb_jtkunio_gfx_rom_arb.sv
// Bench for jtkunio_gfx_rom_arb: SDRAM responder model, request/fill scoreboard
// monitor, and directed scenarios with hand-computed expectations.
module tb_jtkunio_gfx_rom_arb;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic [13:0] char_addr;
    logic [31:0] char_data;
    logic        char_ok;
    logic [16:0] scr_addr;
    logic [31:0] scr_data;
    logic        scr_ok;
    logic        obj_cs;
    logic [17:0] obj_addr;
    logic [31:0] obj_data;
    logic        obj_ok;
    logic [21:0] sdram_addr;
    logic        sdram_req;
    logic        sdram_ack;
    logic        sdram_dst;
    logic [31:0] sdram_din;

    always #5 clk = ~clk;

    jtkunio_gfx_rom_arb dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .char_addr  (char_addr),
        .char_data  (char_data),
        .char_ok    (char_ok),
        .scr_addr   (scr_addr),
        .scr_data   (scr_data),
        .scr_ok     (scr_ok),
        .obj_cs     (obj_cs),
        .obj_addr   (obj_addr),
        .obj_data   (obj_data),
        .obj_ok     (obj_ok),
        .sdram_addr (sdram_addr),
        .sdram_req  (sdram_req),
        .sdram_ack  (sdram_ack),
        .sdram_dst  (sdram_dst),
        .sdram_din  (sdram_din)
    );

    int compared   = 0;
    int mismatched = 0;

    logic [21:0] exp_req [$];
    logic [31:0] exp_c [$];
    logic [31:0] exp_s [$];
    logic [31:0] exp_o [$];

    int   ack_dly  = 1;
    int   dst_dly  = 2;
    bit   mem_en   = 1'b1;
    bit   mem_busy = 1'b0;
    logic [21:0] mem_a;

    logic req_prev = 1'b0;
    logic c_prev = 1'b0, s_prev = 1'b0, o_prev = 1'b0;
    logic [21:0] addr_prev = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end else begin
            $display("ok   %s: %h", name, act);
        end
    endtask

    // SDRAM model: data returned is the requested word address.
    initial begin
        sdram_ack = 1'b0;
        sdram_dst = 1'b0;
        sdram_din = '0;
        forever begin
            @(negedge clk);
            if (mem_en && sdram_req) begin
                mem_busy = 1'b1;
                mem_a    = sdram_addr;
                for (int k = 0; k <= dst_dly; k++) begin
                    sdram_ack = (k == ack_dly);
                    sdram_dst = (k == dst_dly);
                    sdram_din = (k == dst_dly) ? {10'd0, mem_a} : 32'd0;
                    if (k < dst_dly) @(negedge clk);
                end
                @(negedge clk);
                sdram_ack = 1'b0;
                sdram_dst = 1'b0;
                sdram_din = '0;
                mem_busy  = 1'b0;
            end
        end
    end

    // Monitor: pops expected request address on each new request and expected data on each ok rise.
    initial begin
        forever begin
            @(negedge clk);
            #1;
            if (sdram_req && !req_prev) begin
                if (exp_req.size() == 0) begin
                    compared++; mismatched++;
                    $display("FAIL unexpected_req: got addr %h, none expected", sdram_addr);
                end else begin
                    check("req_addr", {10'd0, sdram_addr}, {10'd0, exp_req.pop_front()});
                end
            end
            if (sdram_req && req_prev && (sdram_addr !== addr_prev))
                check("req_addr_stable", {10'd0, sdram_addr}, {10'd0, addr_prev});
            if (char_ok && !c_prev) begin
                if (exp_c.size() == 0) begin
                    compared++; mismatched++;
                    $display("FAIL unexpected_char_ok: data %h", char_data);
                end else check("char_fill", char_data, exp_c.pop_front());
            end
            if (scr_ok && !s_prev) begin
                if (exp_s.size() == 0) begin
                    compared++; mismatched++;
                    $display("FAIL unexpected_scr_ok: data %h", scr_data);
                end else check("scr_fill", scr_data, exp_s.pop_front());
            end
            if (obj_ok && !o_prev) begin
                if (exp_o.size() == 0) begin
                    compared++; mismatched++;
                    $display("FAIL unexpected_obj_ok: data %h", obj_data);
                end else check("obj_fill", obj_data, exp_o.pop_front());
            end
            req_prev  = sdram_req;
            addr_prev = sdram_addr;
            c_prev    = char_ok;
            s_prev    = scr_ok;
            o_prev    = obj_ok;
        end
    end

    task automatic drain(input int maxc);
        int n = 0;
        while ((exp_req.size() != 0 || exp_c.size() != 0 || exp_s.size() != 0 ||
                exp_o.size() != 0 || sdram_req || mem_busy) && n < maxc) begin
            @(negedge clk);
            #2;
            n++;
        end
        compared++;
        if (n >= maxc) begin
            mismatched++;
            $display("FAIL drain: timeout after %0d cycles, %0d requests pending", n, exp_req.size());
            exp_req.delete(); exp_c.delete(); exp_s.delete(); exp_o.delete();
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int viol;
        int n;
        char_addr = 14'h0010;
        scr_addr  = '0;
        obj_cs    = 1'b0;
        obj_addr  = '0;

        // Reset state
        #3 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        check("rst_req",       {31'd0, sdram_req}, 32'd0);
        check("rst_addr",      {10'd0, sdram_addr}, 32'd0);
        check("rst_char_ok",   {31'd0, char_ok}, 32'd0);
        check("rst_scr_ok",    {31'd0, scr_ok}, 32'd0);
        check("rst_obj_ok",    {31'd0, obj_ok}, 32'd0);
        check("rst_char_data", char_data, 32'd0);
        check("rst_scr_data",  scr_data, 32'd0);
        check("rst_obj_data",  obj_data, 32'd0);

        // Char then scroll fill, no object request
        exp_req.push_back(22'h000010); exp_req.push_back(22'h004000);
        exp_c.push_back(32'h00000010); exp_s.push_back(32'h00004000);
        @(negedge clk);
        rst_n = 1'b1;
        drain(60);
        check("t1_char_ok", {31'd0, char_ok}, 32'd1);
        check("t1_scr_ok",  {31'd0, scr_ok}, 32'd1);
        check("t1_obj_ok",  {31'd0, obj_ok}, 32'd0);

        // Fill object slot, then hold all addresses
        @(negedge clk);
        exp_req.push_back(22'h024003); exp_o.push_back(32'h00024003);
        obj_cs = 1'b1; obj_addr = 18'h00003;
        drain(60);
        viol = 0;
        repeat (100) begin
            @(negedge clk);
            #1;
            if (sdram_req || !char_ok || !scr_ok || !obj_ok) viol++;
        end
        check("t2_hold_no_traffic", viol, 32'd0);
        @(negedge clk);
        exp_req.push_back(22'h024005); exp_o.push_back(32'h00024005);
        obj_addr = 18'h00005;
        #1;
        check("t2_obj_ok_drop", {31'd0, obj_ok}, 32'd0);
        check("t2_char_ok_kept", {31'd0, char_ok}, 32'd1);
        drain(60);

        // Char address changes while its fetch is in DATA
        ack_dly = 1; dst_dly = 3;
        @(negedge clk);
        exp_req.push_back(22'h000020); exp_req.push_back(22'h000021);
        exp_c.push_back(32'h00000021);
        char_addr = 14'h0020;
        repeat (3) @(negedge clk);
        char_addr = 14'h0021;
        repeat (2) @(negedge clk);
        #1;
        check("t3_stale_ok",   {31'd0, char_ok}, 32'd0);
        check("t3_stale_data", char_data, 32'h00000020);
        drain(60);
        check("t3_refetch_ok", {31'd0, char_ok}, 32'd1);

        // Three simultaneous misses, then a char miss injected while scr is in flight
        ack_dly = 1; dst_dly = 2;
        @(negedge clk);
        exp_req.push_back(22'h000030); exp_req.push_back(22'h004100); exp_req.push_back(22'h024007);
        exp_c.push_back(32'h00000030); exp_s.push_back(32'h00004100); exp_o.push_back(32'h00024007);
        char_addr = 14'h0030; scr_addr = 17'h00100; obj_addr = 18'h00007;
        drain(80);
        @(negedge clk);
        exp_req.push_back(22'h004101); exp_req.push_back(22'h000031); exp_req.push_back(22'h024008);
        exp_c.push_back(32'h00000031); exp_s.push_back(32'h00004101); exp_o.push_back(32'h00024008);
        scr_addr = 17'h00101; obj_addr = 18'h00008;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!sdram_req && n < 10);
        check("t4_scr_req_seen", {31'd0, sdram_req}, 32'd1);
        char_addr = 14'h0031;
        drain(80);

        // Ack and dst in the same cycle, upper address boundary
        ack_dly = 0; dst_dly = 0;
        @(negedge clk);
        exp_req.push_back(22'h023FFF); exp_s.push_back(32'h00023FFF);
        scr_addr = 17'h1FFFF;
        repeat (2) @(negedge clk);
        #1;
        check("t5_scr_ok_next", {31'd0, scr_ok}, 32'd1);
        check("t5_scr_data",    scr_data, 32'h00023FFF);
        check("t5_idle_no_req", {31'd0, sdram_req}, 32'd0);
        drain(40);
        @(negedge clk);
        exp_req.push_back(22'h063FFF); exp_o.push_back(32'h00063FFF);
        obj_addr = 18'h3FFFF;
        drain(40);
        check("t5_obj_data", obj_data, 32'h00063FFF);

        // Reset during ACK, late dst after release
        ack_dly = 1; dst_dly = 2;
        @(negedge clk);
        mem_en = 1'b0;
        exp_req.push_back(22'h000040);
        char_addr = 14'h0040;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!sdram_req && n < 10);
        check("t6_req_before_rst", {31'd0, sdram_req}, 32'd1);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("t6_rst_req",     {31'd0, sdram_req}, 32'd0);
        check("t6_rst_addr",    {10'd0, sdram_addr}, 32'd0);
        check("t6_rst_char_ok", {31'd0, char_ok}, 32'd0);
        check("t6_rst_scr_ok",  {31'd0, scr_ok}, 32'd0);
        check("t6_rst_obj_ok",  {31'd0, obj_ok}, 32'd0);
        exp_req.push_back(22'h000040); exp_req.push_back(22'h023FFF); exp_req.push_back(22'h063FFF);
        exp_c.push_back(32'h00000040); exp_s.push_back(32'h00023FFF); exp_o.push_back(32'h00063FFF);
        @(negedge clk);
        rst_n = 1'b1;
        sdram_dst = 1'b1;
        sdram_din = 32'hDEADBEEF;
        mem_en = 1'b1;
        @(negedge clk);
        sdram_dst = 1'b0;
        sdram_din = '0;
        #1;
        check("t6_late_dst_ok",   {31'd0, char_ok}, 32'd0);
        check("t6_late_dst_data", char_data, 32'd0);
        drain(100);
        check("t6_char_ok", {31'd0, char_ok}, 32'd1);
        check("t6_scr_ok",  {31'd0, scr_ok}, 32'd1);
        check("t6_obj_ok",  {31'd0, obj_ok}, 32'd1);

        repeat (5) @(negedge clk);
        #2;
        check("end_req_queue", exp_req.size(), 32'd0);
        check("end_fill_queues", exp_c.size() + exp_s.size() + exp_o.size(), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/jtkunio_gfx_rom_arb.md
# jtkunio_gfx_rom_arb

Graphics ROM responder for the Kunio video pipeline. It serves the char, scroll and object ROM read ports: it answers each `*_addr` request with 32-bit `*_data` and an `*_ok` qualifier. It multiplexes the three ports onto one shared SDRAM read channel. Each port has a one-entry tagged cache, so a port whose address is unchanged keeps `*_ok` high without new SDRAM traffic.

## Interface
Parameters:
- `CHAR_OFFSET`, 22'h00000, SDRAM word base for char ROM
- `SCR_OFFSET`, 22'h04000, SDRAM word base for scroll ROM
- `OBJ_OFFSET`, 22'h24000, SDRAM word base for object ROM

Ports:
- `clk` in 1 — system clock, the only clock
- `rst_n` in 1 — asynchronous, active-low reset
- `char_addr` in 14 — char ROM word address; always requested
- `char_data` out 32 — char ROM data
- `char_ok` out 1 — `char_data` is valid for the current `char_addr`
- `scr_addr` in 17 — scroll ROM word address; always requested
- `scr_data` out 32 — scroll ROM data
- `scr_ok` out 1 — `scr_data` is valid for the current `scr_addr`
- `obj_cs` in 1 — object port request enable
- `obj_addr` in 18 — object ROM word address
- `obj_data` out 32 — object ROM data
- `obj_ok` out 1 — `obj_data` is valid for the current `obj_addr`
- `sdram_addr` out 22 — SDRAM read address
- `sdram_req` out 1 — read request
- `sdram_ack` in 1 — SDRAM has accepted the request
- `sdram_dst` in 1 — one-cycle strobe: `sdram_din` valid
- `sdram_din` in 32 — SDRAM read data

## Operation
- Each slot keeps `tag` (address as fetched), `data` and `valid`.
- Outputs per slot:
  - `*_data` = slot `data`.
  - `*_ok` = `valid && tag == *_addr`. This compare is combinational, so an address change drops `ok` in the same cycle.
  - `obj_ok` additionally requires `obj_cs`.
- Miss per slot = not ok. The object slot only counts a miss while `obj_cs` is high.
- Arbitration is fixed priority: char > scr > obj. It is evaluated only in IDLE.
- FSM states:
  - IDLE: if any miss, latch the winner's id and its current address into `req_tag`. Drive `sdram_addr` = OFFSET + zero-extended address (22-bit, modulo 2^22) and `sdram_req`=1. Go to ACK.
  - ACK: hold `sdram_req`/`sdram_addr` until `sdram_ack`. On ack, drop `sdram_req` and go to DATA. If `sdram_dst` arrives in the same cycle as the ack, handle it as in DATA and go directly to IDLE.
  - DATA: on `sdram_dst`, write `data`←`sdram_din`, `tag`←`req_tag` and `valid`←1 into the winner slot. Go to IDLE.
- The fetched tag is the latched request address, not the live input. If the client address changed during a fetch, `ok` stays low after the fill and the next IDLE re-requests.
- If `obj_cs` drops mid-fetch, the fetch completes and fills the slot normally. There is no abort.
- `sdram_ack`/`sdram_dst` seen in IDLE are ignored.
- Reset (asynchronous, any state):
  - FSM goes to IDLE.
  - `sdram_req`=0 and `sdram_addr`=0.
  - All `valid`=0, `tag`=0 and `data`=0, so all `*_ok`=0 and `*_data`=0.
  - A reset in the middle of a transaction abandons it. Any late `sdram_dst` is ignored.

## Timing
- Miss detected in IDLE at cycle n: `sdram_req` and `sdram_addr` are registered and high at n+1.
- `sdram_ack` at cycle a: `sdram_req` is low from a+1.
- `sdram_dst` at cycle d: slot written at the d edge. `*_ok` is high and `*_data` valid at d+1 when the address is unchanged. The FSM is in IDLE at d+1, and the next request can be high at d+2.
- Best-case miss-to-ok latency with ack and dst both at n+1: 2 cycles.
- `sdram_addr` is stable while `sdram_req`=1.
- A hit generates no SDRAM traffic. With all slots hitting, `sdram_req` stays 0 indefinitely.

## Test plan
- Reset, then char_addr=14'h0010, scr_addr=0, obj_cs=0; memory acks 1 cycle and dst 2 cycles after req, `sdram_din`=address → first req addr 22'h000010, second 22'h004000. `char_ok` then `scr_ok` rise with matching data. No obj request.
- All slots filled, addresses held for 100 cycles → `sdram_req` stays 0 and all `ok` stay 1. Then change obj_addr=18'h00005 with obj_cs=1 → `obj_ok` drops the same cycle and req addr 22'h024005.
- Change char_addr while its fetch is in DATA → the stale fill leaves `char_ok`=0, and a second request is issued for the new address.
- All three miss together → service order char, scr, obj. A char miss injected while scr is in flight is served before obj.
- `sdram_ack` and `sdram_dst` in the same cycle → slot filled, `ok` high the next cycle, FSM back in IDLE.
- Assert `rst_n`=0 during ACK → `sdram_req`=0 and all `ok`=0 immediately. A late `sdram_dst` after release writes nothing.
